// File: rtl/ring_counter_param_if.sv
// ----------------------------------------------------------------------------
// ring_counter_param_if
// Groups the control and status signals of ring_counter_param.
//   en    count enable (gates the prescaler)
//   dir   0 = rotate left / count up, 1 = rotate right / count down
//   mode  00 one-hot ring, 01 Johnson, 10 binary, 11 Gray
//   load  synchronous load strobe, seed is the value captured
//   cnt   registered counter state
//   wrap  one-cycle pulse: cnt has just stepped to the home state
//   err   one-cycle pulse: an illegal state was replaced by 1
// The master drives the controls; the slave (the counter) drives status.
// There is no handshake: every control is sampled on each rising clock edge.
// ----------------------------------------------------------------------------
interface ring_counter_param_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic             dir;
   logic [1:0]       mode;
   logic             load;
   logic [WIDTH-1:0] seed;
   logic [WIDTH-1:0] cnt;
   logic             wrap;
   logic             err;

   modport master (
      output en, dir, mode, load, seed,
      input  cnt, wrap, err
   );

   modport slave (
      input  en, dir, mode, load, seed,
      output cnt, wrap, err
   );
endinterface

// File: rtl/ring_counter_param.sv
// ----------------------------------------------------------------------------
// ring_counter_param
// Multi-mode counter (one-hot ring, Johnson, binary, Gray) with a prescaler
// that divides enabled cycles by DIV, a synchronous seed load and automatic
// replacement of illegal states by 1.
//   clk  sole clock, rising edge
//   rst  asynchronous active-high reset (cnt=1, prescaler=0, wrap=0, err=0)
//   bus  ring_counter_param_if slave: en, dir, mode, load, seed -> cnt, wrap, err
// Edge priority: load > correction > step > hold.
// ----------------------------------------------------------------------------
module ring_counter_param #(
   parameter int WIDTH = 8,
   parameter int DIV   = 1
) (
   input logic                clk,
   input logic                rst,
   ring_counter_param_if.slave bus
);

   typedef enum logic [1:0] {
      MODE_RING    = 2'b00,
      MODE_JOHNSON = 2'b01,
      MODE_BINARY  = 2'b10,
      MODE_GRAY    = 2'b11
   } mode_t;

   localparam int               PW         = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0]    PRESC_MAX  = PW'(DIV - 1);
   // Johnson legality only looks at adjacent pairs inside 0..WIDTH-2.
   localparam logic [WIDTH-1:0] PAIR_MASK  = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

   logic [WIDTH-1:0] cnt_q;
   logic [PW-1:0]    presc;
   logic             wrap_q;
   logic             err_q;

   mode_t            mode;
   logic             step;
   logic             legal;
   logic [WIDTH-1:0] cnt_next;
   logic [WIDTH-1:0] home;
   logic [WIDTH-1:0] g2b;
   logic [WIDTH-1:0] bin_next;
   logic [WIDTH-1:0] pairs;

   assign mode = mode_t'(bus.mode);

   always_comb begin
      step     = bus.en && (presc == PRESC_MAX);

      // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
      g2b = '0;
      for (int i = 0; i < WIDTH; i++) begin
         g2b[i] = ^(cnt_q >> i);
      end
      bin_next = bus.dir ? (g2b - ONE) : (g2b + ONE);

      // One bit per adjacent pair that differs.
      pairs    = (cnt_q ^ (cnt_q >> 1)) & PAIR_MASK;

      legal    = 1'b1;
      cnt_next = cnt_q;
      home     = '0;
      case (mode)
         MODE_RING: begin
            legal    = (cnt_q != '0) && ((cnt_q & (cnt_q - ONE)) == '0);
            cnt_next = bus.dir ? {cnt_q[0], cnt_q[WIDTH-1:1]}
                               : {cnt_q[WIDTH-2:0], cnt_q[WIDTH-1]};
            home     = ONE;
         end
         MODE_JOHNSON: begin
            legal    = ((pairs & (pairs - ONE)) == '0);
            cnt_next = bus.dir ? {~cnt_q[0], cnt_q[WIDTH-1:1]}
                               : {cnt_q[WIDTH-2:0], ~cnt_q[WIDTH-1]};
         end
         MODE_BINARY: begin
            cnt_next = bus.dir ? (cnt_q - ONE) : (cnt_q + ONE);
         end
         MODE_GRAY: begin
            cnt_next = bin_next ^ (bin_next >> 1);
         end
         default: begin
            legal    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= ONE;
         presc  <= '0;
         wrap_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         err_q  <= 1'b0;
         if (bus.load) begin
            cnt_q <= bus.seed;
            presc <= '0;
         end else begin
            // The prescaler keeps its cadence even when a correction
            // overrides the step it would have produced.
            if (bus.en) begin
               presc <= step ? '0 : (presc + PW'(1));
            end
            if (!legal) begin
               cnt_q <= ONE;
               err_q <= 1'b1;
            end else if (step) begin
               cnt_q  <= cnt_next;
               wrap_q <= (cnt_next == home);
            end
         end
      end
   end

   assign bus.cnt  = cnt_q;
   assign bus.wrap = wrap_q;
   assign bus.err  = err_q;

endmodule
